// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, drives the instruction memory address and buffers
// {instruction, pc} pairs in a prefetch queue for decode. Option macro: IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  output logic        Fault
);

  localparam int          AW         = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(QUEUE_DEPTH);

  logic [31:0]   r_fpc;
  logic [31:0]   r_qInstr [QUEUE_DEPTH];
  logic [31:0]   r_qPc    [QUEUE_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic          w_redirect;
  logic          w_fetchEn;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_target;

`ifdef IFU_MISALIGN_TRAP_EN
  logic          r_fault;
  logic          w_misaligned;

  // Once faulted the unit is frozen: redirects are ignored and nothing more is fetched.
  assign w_redirect   = Redirect && !r_fault;
  assign w_misaligned = (RedirectPC[1:0] != 2'b00);
  assign w_target     = RedirectPC;
  assign w_fetchEn    = !r_fault;
  assign Fault        = r_fault;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fault <= 1'b0;
    end else if (w_redirect && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_redirect = Redirect;
  assign w_target   = RedirectPC & ~32'h3;
  assign w_fetchEn  = 1'b1;
  assign Fault      = 1'b0;
`endif

  assign Address  = r_fpc;
  assign OutValid = (r_count != '0);

  // Outputs come only from stored entries and read as zero while the queue is empty.
  assign OutInstruction = OutValid ? r_qInstr[r_head]        : '0;
  assign OutPC          = OutValid ? r_qPc[r_head]           : '0;
  assign OutPCPlus4     = OutValid ? r_qPc[r_head] + 32'd4   : '0;

  // A full queue never accepts a push, even when the head leaves in the same cycle.
  assign w_push = !w_redirect && (r_count != FULL_COUNT) && w_fetchEn;
  assign w_pop  = !w_redirect && OutValid && OutReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fpc   <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_qInstr[i] <= '0;
        r_qPc[i]    <= '0;
      end
    end else if (w_redirect) begin
      r_fpc   <= w_target;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_qInstr[r_tail] <= Instruction;
        r_qPc[r_tail]    <= r_fpc;
        r_tail           <= r_tail + AW'(1);
        r_fpc            <= r_fpc + 32'd4;
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random redirects and
// back-pressure, with a fetch-stream scoreboard checked by an independent output monitor.
module tb_instruction_fetch_unit;

  localparam int          QD     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] OutInstruction;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic        Fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      expQ[$];
  logic [31:0] modelNextPc = '0;
  bit          streamActive = 1'b0;
  int          nChecks = 0;
  int          nFailures = 0;
  int          nTransfers = 0;
  logic [31:0] mem [128];

  always #5 Clk = ~Clk;

  assign Instruction = mem[Address[8:2]];

  instruction_fetch_unit #(.QUEUE_DEPTH(QD), .RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Instruction(Instruction),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .OutValid(OutValid), .OutReady(OutReady),
    .OutInstruction(OutInstruction), .OutPC(OutPC), .OutPCPlus4(OutPCPlus4), .Fault(Fault)
  );

  // Memory image is mem[i] = i*3 and aliases every 512 bytes.
  function automatic logic [31:0] expInstr(input logic [31:0] pc);
    return 32'(((pc / 4) % 128) * 3);
  endfunction

  // Keep a window of upcoming fetch-order entries queued for the monitor.
  function automatic void refill();
    entry_t e;
    while (streamActive && expQ.size() < 16) begin
      e.pc = modelNextPc;
      e.instr = expInstr(modelNextPc);
      expQ.push_back(e);
      modelNextPc = modelNextPc + 32'd4;
    end
  endfunction

  function automatic void startStream(input logic [31:0] pc);
    expQ.delete();
    modelNextPc = pc;
    streamActive = 1'b1;
    refill();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFailures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge Clk);
    #1;
  endtask

  // Drive the inputs for the next edge; a redirect restarts (or halts) the expected stream.
  task automatic applyStimulus(input bit redir, input logic [31:0] pc, input bit ready);
    Redirect = redir;
    RedirectPC = pc;
    OutReady = ready;
    if (redir) begin
`ifdef IFU_MISALIGN_TRAP_EN
      if (!streamActive || pc[1:0] != 2'b00) begin
        expQ.delete();
        streamActive = 1'b0;
      end else begin
        startStream(pc);
      end
`else
      startStream(pc & ~32'h3);
`endif
    end
  endtask

  // Called just after a rising edge; the pulse lands and clears well before the next edge.
  task automatic pulseReset();
    #2 Reset = 1'b1;
    #1;
    checkOutput("asyncResetValid", 32'(OutValid), 32'd0);
    checkOutput("asyncResetAddr", Address, RST_PC);
    Reset = 1'b0;
    startStream(RST_PC);
  endtask

  // Output monitor: compares the head entry to the scoreboard and retires it on a handshake.
  always @(negedge Clk) begin
    entry_t e;
    if (!Reset && !Redirect) begin
      if (OutValid) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFailures++;
          $display("[TB] FAIL unexpectedEntry: got pc 0x%08h, expected no entry at %0t", OutPC, $time);
        end else begin
          e = expQ[0];
          checkOutput("outPc", OutPC, e.pc);
          checkOutput("outInstr", OutInstruction, e.instr);
          checkOutput("outPcPlus4", OutPCPlus4, e.pc + 32'd4);
          if (OutReady) begin
            void'(expQ.pop_front());
            nTransfers++;
            refill();
          end
        end
      end else begin
        checkOutput("idleOutZero", OutPC | OutInstruction | OutPCPlus4, 32'd0);
      end
    end
  end

  initial begin
    bit          redir;
    logic [31:0] target;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3);

    // Reset state while held.
    #2;
    checkOutput("resetValid", 32'(OutValid), 32'd0);
    checkOutput("resetAddr", Address, RST_PC);
    checkOutput("resetOutPc", OutPC, 32'd0);
    checkOutput("resetFault", 32'(Fault), 32'd0);

    // Release: first entry after one edge, then one per cycle.
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    OutReady = 1'b1;
    startStream(RST_PC);
    waitCycle();
    checkOutput("firstValid", 32'(OutValid), 32'd1);
    checkOutput("firstPc", OutPC, RST_PC);
    for (int k = 1; k <= 4; k++) begin
      waitCycle();
      checkOutput("streamValid", 32'(OutValid), 32'd1);
      checkOutput("streamPc", OutPC, RST_PC + 32'(4 * k));
      checkOutput("streamInstr", OutInstruction, 32'(3 * k));
    end

    // Back-pressure: queue saturates and fetch address holds.
    pulseReset();
    OutReady = 1'b0;
    repeat (6) waitCycle();
    checkOutput("fullAddrHold", Address, RST_PC + 32'h10);
    checkOutput("fullHeadPc", OutPC, RST_PC);
    OutReady = 1'b1;
    repeat (8) waitCycle();

    // Redirect with three queued entries.
    pulseReset();
    OutReady = 1'b0;
    repeat (3) waitCycle();
    checkOutput("threeQueuedAddr", Address, RST_PC + 32'hC);
    applyStimulus(1'b1, 32'h40, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redirBubble", 32'(OutValid), 32'd0);
    checkOutput("redirAddr", Address, 32'h40);
    waitCycle();
    checkOutput("redirValid", 32'(OutValid), 32'd1);
    checkOutput("redirPc", OutPC, 32'h40);
    checkOutput("redirInstr", OutInstruction, 32'd48);
    OutReady = 1'b1;
    repeat (3) waitCycle();

    // Alias across the 512-byte boundary.
    applyStimulus(1'b1, 32'h1FC, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("aliasBubble", 32'(OutValid), 32'd0);
    waitCycle();
    checkOutput("aliasPc0", OutPC, 32'h1FC);
    waitCycle();
    checkOutput("aliasPc1", OutPC, 32'h200);
    checkOutput("aliasInstr", OutInstruction, 32'd0);
    checkOutput("aliasPlus4", OutPCPlus4, 32'h204);

    // Misaligned redirect.
    applyStimulus(1'b1, 32'h42, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef IFU_MISALIGN_TRAP_EN
    checkOutput("faultSet", 32'(Fault), 32'd1);
    applyStimulus(1'b1, 32'h80, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      checkOutput("faultHalted", 32'(OutValid), 32'd0);
      waitCycle();
    end
    checkOutput("faultAddrHold", Address, 32'h42);
    checkOutput("faultSticky", 32'(Fault), 32'd1);
    pulseReset();
    checkOutput("faultCleared", 32'(Fault), 32'd0);
`else
    checkOutput("misalignAddr", Address, 32'h40);
    waitCycle();
    checkOutput("misalignPc", OutPC, 32'h40);
    checkOutput("noFault", 32'(Fault), 32'd0);
`endif

    // Asynchronous reset from a full queue, then restart.
    pulseReset();
    OutReady = 1'b0;
    repeat (6) waitCycle();
    checkOutput("fullBeforeReset", Address, RST_PC + 32'h10);
    pulseReset();
    waitCycle();
    checkOutput("restartValid", 32'(OutValid), 32'd1);
    checkOutput("restartPc", OutPC, RST_PC);

    // Random redirects (including near the top of the address space) and back-pressure.
    for (int c = 0; c < 400; c++) begin
      redir = ($urandom_range(0, 15) == 0);
      target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
      target = target & ~32'h3;
`endif
      applyStimulus(redir, target, $urandom_range(0, 3) != 0);
      waitCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (4) waitCycle();

    nChecks++;
    if (nTransfers < 100) begin
      nFailures++;
      $display("[TB] FAIL transferCount: got %0d, expected at least 100", nTransfers);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFailures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Fetch front end that drives the instruction memory: owns the program counter, presents `Address`, and captures the returned `Instruction` into a small prefetch queue.
- Queue entries are handed to decode over a valid/ready handshake.
- Sits between the PC/branch logic and the decode stage; the instruction memory it drives is combinational, with a 128-word, byte-addressed space indexed by `Address[8:2]`.

## Interface
Parameters:
- `QUEUE_DEPTH`, 4 — prefetch queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h00000000 — fetch PC loaded on reset; must be word-aligned.

Ports:
- `Clk`  in  1  — single clock; all state updates on rising edge.
- `Reset`  in  1  — asynchronous, active-high; clears all state immediately.
- `Address`  out  32  — fetch address to instruction memory; equals the fetch PC register.
- `Instruction`  in  32  — memory read data, valid in the same cycle as `Address`.
- `Redirect`  in  1  — taken branch/jump; sampled on the rising edge.
- `RedirectPC`  in  32  — target PC, qualified by `Redirect`.
- `OutValid`  out  1  — head queue entry present.
- `OutReady`  in  1  — decode accepts the head entry.
- `OutInstruction`  out  32  — instruction of the head entry.
- `OutPC`  out  32  — PC of the head entry.
- `OutPCPlus4`  out  32  — `OutPC` + 4, modulo 2^32.
- `Fault`  out  1  — sticky misaligned-redirect flag; tied 0 when `IFU_MISALIGN_TRAP_EN` is undefined.

## Operation
State:
- Fetch PC register (FPC).
- Queue of {instruction, pc} entries with head/tail pointers and an occupancy count (0..`QUEUE_DEPTH`).
- Fault flag.

Per-edge priority:
1. `Reset`:
   - FPC = `RESET_PC`; queue empty; `Fault` = 0.
   - `OutValid` = 0, and `OutInstruction`/`OutPC`/`OutPCPlus4` = 0 while empty.
2. `Redirect` = 1:
   - Flush the queue (count = 0). A pop in the same cycle is absorbed by the flush.
   - FPC = `RedirectPC`. Nothing is enqueued this cycle.
3. Otherwise:
   - Push: if count < `QUEUE_DEPTH` and `Fault` = 0, enqueue {`Instruction`, FPC} and FPC += 4.
   - Pop: if `OutValid` && `OutReady`, advance the head.
   - Push and pop in one cycle: both happen and count is unchanged.
   - Full queue: no push, even if a pop occurs that cycle (no full-bypass); FPC holds.

Other rules:
- Output signals come from stored queue entries only; no combinational path from `Instruction` to the `Out*` ports.
- All `Out*` data ports are 0 whenever `OutValid` = 0.
- FPC arithmetic is 32-bit and wraps modulo 2^32; the unit imposes no memory bound.
- Addresses alias every 512 bytes in memory because only `Address[8:2]` is decoded.
- Entries leave in strict fetch order. The PC sequence is gapless except across a redirect.

## Timing
- `Address` changes only after a rising edge or on asynchronous `Reset`.
- Reset release to first entry: first edge enqueues PC `RESET_PC`; `OutValid` = 1 after that edge (latency 1).
- Steady state with `OutReady` held at 1: one instruction per cycle, no bubbles.
- Redirect at edge N:
  - After N: `OutValid` = 0 and `Address` = target.
  - After N+1: `OutValid` = 1 with `OutPC` = target (one bubble).
- Back-to-back redirects: each one restarts this sequence; only the last target is fetched.
- Reset asserted mid-cycle: `OutValid` falls and `Address` = `RESET_PC` without waiting for `Clk`.

## Configuration
`IFU_MISALIGN_TRAP_EN`:
- Defined:
  - A redirect with `RedirectPC[1:0]` ≠ 0 flushes the queue and sets `Fault` = 1.
  - Fetch then halts: no pushes, `OutValid` stays 0, FPC holds the misaligned target.
  - Only `Reset` clears the fault; later redirects are ignored.
- Undefined:
  - `RedirectPC[1:0]` is forced to 00 when loaded into FPC.
  - `Fault` is constant 0.

## Test plan
- Reset, memory image mem[i] = i*3, `OutReady` = 1 → after the first edge, `OutPC` = 0, 4, 8, 12 on consecutive cycles, with `OutInstruction` = 0, 3, 6, 9.
- `OutReady` = 0 for 6 cycles after reset → count saturates at 4 and `Address` holds 0x10. Then `OutReady` = 1 → `OutPC` = 0x0, 0x4, 0x8, 0xC, 0x10 in order, with no loss or duplicates.
- Queue holding 3 entries, `Redirect` = 1 with `RedirectPC` = 0x40 → next cycle `OutValid` = 0; following cycle `OutPC` = 0x40 with `OutInstruction` = mem[16] = 48.
- `RedirectPC` = 0x1FC → `OutPC` = 0x1FC then 0x200; the 0x200 entry has `OutInstruction` = mem[0] = 0 (alias) and `OutPCPlus4` = 0x204.
- `RedirectPC` = 0x42:
  - Macro defined → `Fault` = 1 and `OutValid` stays 0 for 10 cycles despite a later redirect to 0x80.
  - Macro undefined → `OutPC` = 0x40.
- Full queue, `Reset` pulsed asynchronously between edges → `OutValid` = 0 and `Address` = `RESET_PC` before the next edge; fetch restarts at `RESET_PC` after release.
